// File: rtl/core_pkg.sv
// Shared core types: data width, register index/word types and writeback result select.
package core_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [4:0]      reg_idx_t;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read one-write architectural register file with x0 hardwired to zero and
// same-cycle write-through bypass on both read ports.
module regfile_2r1w
  import core_pkg::*;
#(
  parameter int unsigned XLEN = core_pkg::XLEN,
  parameter int unsigned NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_we,
  input  reg_idx_t        i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  reg_idx_t        i_a1,
  input  reg_idx_t        i_a2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_regs [NREG];

  // Entry 0 is cleared on reset and never written; reads of x0 are masked anyway.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  logic w_hit1;
  logic w_hit2;

  assign w_hit1 = i_we && (i_waddr != '0) && (i_a1 == i_waddr);
  assign w_hit2 = i_we && (i_waddr != '0) && (i_a2 == i_waddr);

  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (i_a1 != '0) begin
      o_rd1 = w_hit1 ? i_wdata : r_regs[i_a1];
    end
    if (i_a2 != '0) begin
      o_rd2 = w_hit2 ? i_wdata : r_regs[i_a2];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, register file commit with decode read ports,
// execute forwarding value and retired-instruction counter.
module wb_regfile
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = core_pkg::XLEN,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_w_i,
  input  logic             reg_write_w_i,
  input  logic [1:0]       result_src_w_i,
  input  logic [XLEN-1:0]  alu_result_w_i,
  input  logic [XLEN-1:0]  read_data_w_i,
  input  logic [XLEN-1:0]  pc_plus4_w_i,
  input  reg_idx_t         rd_w_i,
  input  reg_idx_t         a1_d_i,
  input  reg_idx_t         a2_d_i,
  output logic [XLEN-1:0]  rd1_d_o,
  output logic [XLEN-1:0]  rd2_d_o,
  output logic [XLEN-1:0]  result_w_o,
  output logic [CNT_W-1:0] instret_o
);

  logic [XLEN-1:0]  w_result;
  logic             w_we;
  logic [CNT_W-1:0] r_instret;

  // Reserved select 2'b11 falls back to the ALU result.
  always_comb begin
    w_result = alu_result_w_i;
    unique case (result_src_w_i)
      RES_ALU: w_result = alu_result_w_i;
      RES_MEM: w_result = read_data_w_i;
      RES_PC4: w_result = pc_plus4_w_i;
      default: w_result = alu_result_w_i;
    endcase
  end

  assign w_we       = valid_w_i && reg_write_w_i && (rd_w_i != '0);
  assign result_w_o = w_result;

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_rf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (w_we),
    .i_waddr (rd_w_i),
    .i_wdata (w_result),
    .i_a1    (a1_d_i),
    .i_a2    (a2_d_i),
    .o_rd1   (rd1_d_o),
    .o_rd2   (rd2_d_o)
  );

  // Counts every retired slot, writing or not; wraps silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_instret <= '0;
    end else if (valid_w_i) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign instret_o = r_instret;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: array/counter model checked every cycle plus
// hand-computed literal checks along a directed sequence.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        rw;
  logic [1:0]  src;
  logic [31:0] alu;
  logic [31:0] rdata;
  logic [31:0] pc4;
  logic [4:0]  rd;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] res;
  logic [63:0] instret;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_regs [32];
  logic [63:0] m_instret;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .valid_w_i      (valid),
    .reg_write_w_i  (rw),
    .result_src_w_i (src),
    .alu_result_w_i (alu),
    .read_data_w_i  (rdata),
    .pc_plus4_w_i   (pc4),
    .rd_w_i         (rd),
    .a1_d_i         (a1),
    .a2_d_i         (a2),
    .rd1_d_o        (rd1),
    .rd2_d_o        (rd2),
    .result_w_o     (res),
    .instret_o      (instret)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_sel();
    case (src)
      2'b01:   return rdata;
      2'b10:   return pc4;
      default: return alu;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (valid && rw && rd != 5'd0 && a == rd) return m_sel();
    return m_regs[a];
  endfunction

  // Model state advances on the same edge as the DUT.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_instret = 64'd0;
    end else begin
      if (valid) m_instret = m_instret + 64'd1;
      if (valid && rw && rd != 5'd0) m_regs[rd] = m_sel();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_result", res, m_sel());
      chk("model_rd1", rd1, m_read(a1));
      chk("model_rd2", rd2, m_read(a2));
      chk("model_instret", instret, m_instret);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] s, input logic [31:0] al,
                       input logic [31:0] rdt, input logic [31:0] p4, input logic [4:0] d,
                       input logic [4:0] r1, input logic [4:0] r2);
    valid = v; rw = w; src = s; alu = al; rdata = rdt; pc4 = p4; rd = d; a1 = r1; a2 = r2;
    #2;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31);
    chk("reset_instret", instret, 64'd0);
    chk("reset_x5", rd1, 32'd0);
    chk("reset_x31", rd2, 32'd0);

    // Write x5 then read it back.
    tick();
    drive(1'b1, 1'b1, 2'b00, 32'hDEADBEEF, 32'd0, 32'd0, 5'd5, 5'd0, 5'd0);
    chk("alu_result", res, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
    chk("x5_read", rd1, 32'hDEADBEEF);
    chk("instret_1", instret, 64'd1);

    // Same-cycle bypass on both ports.
    tick();
    drive(1'b1, 1'b1, 2'b10, 32'd0, 32'd0, 32'h00000104, 5'd7, 5'd7, 5'd7);
    chk("bypass_rd1", rd1, 32'h00000104);
    chk("bypass_rd2", rd2, 32'h00000104);

    // x0 write discarded.
    tick();
    drive(1'b1, 1'b1, 2'b00, 32'h12345678, 32'd0, 32'd0, 5'd0, 5'd0, 5'd7);
    chk("x0_same", rd1, 32'd0);
    chk("x7_array", rd2, 32'h00000104);
    tick();
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    chk("x0_next", rd1, 32'd0);
    chk("instret_3", instret, 64'd3);

    // Bubble: no write, no bypass, no count.
    tick();
    drive(1'b0, 1'b1, 2'b01, 32'd0, 32'hFFFF0000, 32'd0, 5'd3, 5'd3, 5'd0);
    chk("bubble_nobypass", rd1, 32'd0);
    tick();
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd0);
    chk("bubble_x3", rd1, 32'd0);
    chk("bubble_instret", instret, 64'd3);

    // Load path and reserved select.
    tick();
    drive(1'b1, 1'b1, 2'b01, 32'h0, 32'hCAFEF00D, 32'd0, 5'd9, 5'd0, 5'd0);
    chk("load_result", res, 32'hCAFEF00D);
    tick();
    drive(1'b1, 1'b1, 2'b11, 32'h55, 32'hAAAAAAAA, 32'hBBBBBBBB, 5'd10, 5'd9, 5'd0);
    chk("x9_load", rd1, 32'hCAFEF00D);
    chk("src11_result", res, 32'h55);
    tick();
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd10, 5'd5);
    chk("x10_src11", rd1, 32'h55);
    chk("x5_kept", rd2, 32'hDEADBEEF);
    chk("instret_5", instret, 64'd5);

    // Valid but non-writing instruction still retires.
    tick();
    drive(1'b1, 1'b0, 2'b00, 32'h77, 32'd0, 32'd0, 5'd5, 5'd5, 5'd0);
    chk("nowrite_nobypass", rd1, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
    chk("nowrite_x5", rd1, 32'hDEADBEEF);
    chk("instret_6", instret, 64'd6);

    // Reset mid-stream with a concurrent write.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, 2'b00, 32'h100 * i, 32'd0, 32'd0, 5'(i), 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd2, 5'd4);
    chk("pre_rst_x2", rd1, 32'h200);
    chk("pre_rst_x4", rd2, 32'h400);
    chk("pre_rst_instret", instret, 64'd4);
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 32'h99, 32'd0, 32'd0, 5'd2, 5'd2, 5'd1);
    chk("rst_bypass", rd1, 32'h99);
    chk("rst_x1_before_edge", rd2, 32'h100);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd2);
    chk("post_rst_x1", rd1, 32'd0);
    chk("post_rst_x2", rd2, 32'd0);
    chk("post_rst_instret", instret, 64'd0);
    tick();
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd4);
    chk("post_rst_x3", rd1, 32'd0);
    chk("post_rst_x4", rd2, 32'd0);

    // Mixed traffic checked against the model on every cycle.
    for (int n = 0; n < 300; n++) begin
      tick();
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), $urandom, $urandom,
            $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
    end

    tick();
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback result and commits it to the 32x32 architectural register file.
- Serves the two decode-stage read ports with same-cycle write-through bypass.
- Drives the forwarding result to execute and maintains a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, data width of registers and results.
- NREG, 32, number of architectural registers (x0 hardwired zero).
- CNT_W, 64, width of retired-instruction counter.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- valid_w_i  in  1  W-stage slot holds a real instruction (0 = bubble/flush)
- reg_write_w_i  in  1  instruction writes rd
- result_src_w_i  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved
- alu_result_w_i  in  XLEN  ALU result from MEM/WB register
- read_data_w_i  in  XLEN  load data from MEM/WB register
- pc_plus4_w_i  in  XLEN  PC+4 from MEM/WB register
- rd_w_i  in  5  destination register index
- a1_d_i  in  5  decode read index 1
- a2_d_i  in  5  decode read index 2
- rd1_d_o  out  XLEN  read data 1
- rd2_d_o  out  XLEN  read data 2
- result_w_o  out  XLEN  selected writeback value, for execute-stage forwarding
- instret_o  out  CNT_W  retired-instruction count

Behaviour:
- Result mux (combinational):
  - 00 → alu_result_w_i; 01 → read_data_w_i; 10 → pc_plus4_w_i.
  - 11 → alu_result_w_i (defined fallback, no X).
- Write enable: we = valid_w_i & reg_write_w_i & (rd_w_i != 0).
  - On the rising edge with we=1, reg[rd_w_i] <= result_w_o.
  - Writes to x0 are discarded, and x0 always reads 0.
- Read ports (combinational):
  - rdN_d_o = 0 if aN_d_i == 0.
  - Else result_w_o if we & (aN_d_i == rd_w_i) (write-through bypass; replaces a negative-edge write).
  - Else reg[aN_d_i].
- Both read ports may address the same register. Both may hit the bypass in the same cycle.
- instret_o:
  - Increments by 1 on each rising edge with valid_w_i=1, whether or not the instruction writes a register.
  - Wraps from all-ones to 0 with no flag.
- Reset (rst_i=1 at the rising edge):
  - All registers x1..x31 cleared to 0 and instret_o cleared to 0.
  - Reset overrides any write or increment in that cycle.
- Outputs during and after reset:
  - While rst_i is asserted, rd1_d_o/rd2_d_o still follow the combinational rule above, so bypass is active if we=1.
  - After the reset edge, all reads return 0 until the next write.
- Latency:
  - Read: 0 cycles.
  - Write visible in the array 1 cycle after the edge; visible through bypass in the same cycle.
  - instret_o reflects retirement 1 cycle after the edge.
- No stall input: W stage never stalls; bubbles arrive as valid_w_i=0.

Decomposition:
- Shared package (core_pkg):
  - XLEN.
  - Typedef reg_idx_t (5-bit) and typedef word_t.
  - Enum result_src_e {RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10}.
- One natural sub-module: regfile_2r1w.
  - Contains the array, x0 masking and bypass.
  - Result mux and instret counter stay in the top.

Test Plan:
- Write/read: valid=1, reg_write=1, src=00, alu=0xDEADBEEF, rd=5; next cycle a1=5 → rd1_d_o=0xDEADBEEF; instret_o=1.
- Same-cycle bypass: valid=1, reg_write=1, src=10, pc_plus4=0x00000104, rd=7, a1=a2=7 in the same cycle → rd1_d_o=rd2_d_o=0x00000104 combinationally.
- x0 protection: write rd=0 with alu=0x12345678 → a1=0 reads 0 both same cycle and next cycle; instret_o increments by 1.
- Bubble: reg_write=1, valid=0, rd=3, read_data=0xFFFF0000, src=01 → x3 unchanged (0), no bypass, instret_o unchanged.
- Load path and src=11: src=01, read_data=0xCAFEF00D into x9 → x9=0xCAFEF00D; src=11, alu=0x55 into x10 → x10=0x55.
- Reset mid-stream: x1..x4 written with nonzero values, instret_o=4; assert rst_i with a concurrent write to x2=0x99 → next cycle x1..x4 read 0, instret_o=0.
